// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and request type for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned RF_SEL_W    = 4;
    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_NUM_REGS = 16;

    // Wide enough for the largest legal starvation limit (15).
    localparam int unsigned WAIT_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [RF_SEL_W-1:0]  ws;
        logic [RF_DATA_W-1:0] wd;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_grant.sv
// Fixed-priority grant (A first) with a saturating wait counter that forces B
// through after it has been refused P_MAX_WAIT cycles in a row.
module regfile_wb_grant
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned P_MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic a_valid_i,
    input  logic b_valid_i,
    output logic a_grant_o,
    output logic b_grant_o,
    output logic force_b_o
);

    localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(P_MAX_WAIT);

    logic [WAIT_W-1:0] wait_q, wait_d;

    always_comb begin
        force_b_o = (wait_q == MAX_WAIT);
        b_grant_o = b_valid_i && (force_b_o || !a_valid_i);
        a_grant_o = a_valid_i && !b_grant_o;
        wait_d    = '0;
        if (b_valid_i && !b_grant_o) begin
            wait_d = (wait_q == MAX_WAIT) ? wait_q : wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between ALU (A) and load unit (B),
// registers the winning write and offers a bypass for the pending write.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned P_MAX_WAIT = 4,
    parameter int unsigned P_DATA_W   = RF_DATA_W,
    parameter int unsigned P_SEL_W    = RF_SEL_W
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_a_valid,
    output logic                o_a_ready,
    input  logic [P_SEL_W-1:0]  i_a_ws,
    input  logic [P_DATA_W-1:0] i_a_wd,
    input  logic                i_b_valid,
    output logic                o_b_ready,
    input  logic [P_SEL_W-1:0]  i_b_ws,
    input  logic [P_DATA_W-1:0] i_b_wd,
    output logic                o_we,
    output logic [P_SEL_W-1:0]  o_ws,
    output logic [P_DATA_W-1:0] o_wd,
    input  logic [P_SEL_W-1:0]  i_rs1,
    input  logic [P_SEL_W-1:0]  i_rs2,
    output logic                o_fwd1,
    output logic                o_fwd2,
    output logic [P_DATA_W-1:0] o_fwd_data,
    output logic                o_b_starved
);

    logic                a_grant, b_grant, force_b;
    logic                we_q, we_d;
    logic [P_SEL_W-1:0]  ws_q, ws_d;
    logic [P_DATA_W-1:0] wd_q, wd_d;

    regfile_wb_grant #(
        .P_MAX_WAIT(P_MAX_WAIT)
    ) u_grant (
        .clk_i    (i_clk),
        .rst_ni   (i_reset_n),
        .a_valid_i(i_a_valid),
        .b_valid_i(i_b_valid),
        .a_grant_o(a_grant),
        .b_grant_o(b_grant),
        .force_b_o(force_b)
    );

    assign o_a_ready   = a_grant;
    assign o_b_ready   = b_grant;
    assign o_b_starved = force_b;

    // Selector and data hold their last values when no write is granted.
    always_comb begin
        we_d = a_grant || b_grant;
        ws_d = ws_q;
        wd_d = wd_q;
        if (a_grant) begin
            ws_d = i_a_ws;
            wd_d = i_a_wd;
        end else if (b_grant) begin
            ws_d = i_b_ws;
            wd_d = i_b_wd;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            we_q <= 1'b0;
            ws_q <= '0;
            wd_q <= '0;
        end else begin
            we_q <= we_d;
            ws_q <= ws_d;
            wd_q <= wd_d;
        end
    end

    assign o_we       = we_q;
    assign o_ws       = ws_q;
    assign o_wd       = wd_q;
    assign o_fwd1     = we_q && (i_rs1 == ws_q);
    assign o_fwd2     = we_q && (i_rs2 == ws_q);
    assign o_fwd_data = wd_q;

`ifndef SYNTHESIS
    // A refused requester must keep its request unchanged until accepted.
    a_hold: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (i_a_valid && !o_a_ready) |=> (i_a_valid && $stable(i_a_ws) && $stable(i_a_wd)));
    b_hold: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (i_b_valid && !o_b_ready) |=> (i_b_valid && $stable(i_b_ws) && $stable(i_b_wd)));
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int P_MAX_WAIT = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    wb_req_t              req_a, req_b;
    logic [RF_SEL_W-1:0]  rs1, rs2;
    logic                 a_ready, b_ready, we, fwd1, fwd2, starved;
    logic [RF_SEL_W-1:0]  ws;
    logic [RF_DATA_W-1:0] wd, fwd_data;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: last registered write and consecutive B refusals.
    logic                 m_we;
    logic [RF_SEL_W-1:0]  m_ws;
    logic [RF_DATA_W-1:0] m_wd;
    int                   m_refused;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .P_MAX_WAIT(P_MAX_WAIT),
        .P_DATA_W  (RF_DATA_W),
        .P_SEL_W   (RF_SEL_W)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_a_valid  (req_a.valid),
        .o_a_ready  (a_ready),
        .i_a_ws     (req_a.ws),
        .i_a_wd     (req_a.wd),
        .i_b_valid  (req_b.valid),
        .o_b_ready  (b_ready),
        .i_b_ws     (req_b.ws),
        .i_b_wd     (req_b.wd),
        .o_we       (we),
        .o_ws       (ws),
        .o_wd       (wd),
        .i_rs1      (rs1),
        .i_rs2      (rs2),
        .o_fwd1     (fwd1),
        .o_fwd2     (fwd2),
        .o_fwd_data (fwd_data),
        .o_b_starved(starved)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=0x%h expected=0x%h", name, $time, got, exp);
        end
    endtask

    // B wins when it has been refused P_MAX_WAIT times running, or A is idle.
    function automatic logic [1:0] pick(input logic a, input logic b, input int refused);
        logic gb;
        gb = b && ((refused >= P_MAX_WAIT) || !a);
        return {a && !gb, gb};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [1:0] g;
        if (!rst_n) begin
            m_we      <= 1'b0;
            m_ws      <= '0;
            m_wd      <= '0;
            m_refused <= 0;
        end else begin
            g = pick(req_a.valid, req_b.valid, m_refused);
            m_we <= g[1] | g[0];
            if (g[1]) begin
                m_ws <= req_a.ws;
                m_wd <= req_a.wd;
            end else if (g[0]) begin
                m_ws <= req_b.ws;
                m_wd <= req_b.wd;
            end
            if (req_b.valid && !g[0])
                m_refused <= (m_refused + 1 > P_MAX_WAIT) ? P_MAX_WAIT : m_refused + 1;
            else
                m_refused <= 0;
        end
    end

    always @(negedge clk) begin
        logic [1:0] g;
        if (chk_en && rst_n) begin
            g = pick(req_a.valid, req_b.valid, m_refused);
            check("a_ready", 32'(a_ready), 32'(g[1]));
            check("b_ready", 32'(b_ready), 32'(g[0]));
            check("b_starved", 32'(starved), 32'(m_refused >= P_MAX_WAIT));
            check("we", 32'(we), 32'(m_we));
            check("ws", 32'(ws), 32'(m_ws));
            check("wd", wd, m_wd);
            check("fwd1", 32'(fwd1), 32'(m_we && (rs1 == m_ws)));
            check("fwd2", 32'(fwd2), 32'(m_we && (rs2 == m_ws)));
            check("fwd_data", fwd_data, m_wd);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        int   bw;
        logic ar, br;
        req_a = '0;
        req_b = '0;
        rs1   = '0;
        rs2   = '0;

        repeat (2) next();
        at_neg();
        check("rst_we", 32'(we), 0);
        check("rst_ws", 32'(ws), 0);
        check("rst_wd", wd, 0);
        check("rst_starved", 32'(starved), 0);
        check("rst_a_ready", 32'(a_ready), 0);
        check("rst_b_ready", 32'(b_ready), 0);
        next();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        next();

        // Single A write and its one-cycle strobe.
        req_a = '{valid: 1'b1, ws: 4'd3, wd: 32'hDEADBEEF};
        at_neg();
        check("t1_a_ready", 32'(a_ready), 1);
        next();
        req_a.valid = 1'b0;
        at_neg();
        check("t1_we", 32'(we), 1);
        check("t1_ws", 32'(ws), 3);
        check("t1_wd", wd, 32'hDEADBEEF);
        next();
        at_neg();
        check("t1_we_off", 32'(we), 0);
        check("t1_ws_hold", 32'(ws), 3);
        next();

        // Both requesting: B forced through every fifth grant.
        req_a = '{valid: 1'b1, ws: 4'd1, wd: $urandom};
        req_b = '{valid: 1'b1, ws: 4'd2, wd: 32'hB0B0_0002};
        bw = 0;
        for (int k = 0; k <= 10; k++) begin
            at_neg();
            if (k < 10) begin
                check("t2_b_ready", 32'(b_ready), 32'((k % 5) == 4));
                check("t2_starved", 32'(starved), 32'((k % 5) == 4));
                bw += int'(b_ready);
            end else begin
                check("t2_a_last", 32'(a_ready), 1);
            end
            ar = a_ready;
            next();
            if (k == 9) req_b.valid = 1'b0;
            if (k == 10) req_a.valid = 1'b0;
            else if (ar) req_a.wd = $urandom;
        end
        check("t2_b_writes", 32'(bw), 2);
        next();

        // B only, back-to-back.
        req_b = '{valid: 1'b1, ws: 4'd5, wd: 32'h0000_0500};
        for (int i = 0; i <= 3; i++) begin
            at_neg();
            if (i < 3) begin
                check("t3_b_ready", 32'(b_ready), 1);
                check("t3_starved", 32'(starved), 0);
            end
            if (i > 0) begin
                check("t3_we", 32'(we), 1);
                check("t3_ws", 32'(ws), 32'(4 + i));
            end
            next();
            if (i < 2) begin
                req_b.ws = 4'(6 + i);
                req_b.wd = 32'(32'h600 + 32'h100 * i);
            end else begin
                req_b.valid = 1'b0;
            end
        end
        next();

        // Bypass while the write is pending.
        req_a = '{valid: 1'b1, ws: 4'd9, wd: 32'h12345678};
        next();
        req_a.valid = 1'b0;
        rs1 = 4'd9;
        rs2 = 4'd8;
        at_neg();
        check("t4_fwd1", 32'(fwd1), 1);
        check("t4_fwd2", 32'(fwd2), 0);
        check("t4_fwd_data", fwd_data, 32'h12345678);
        next();
        at_neg();
        check("t4_fwd1_idle", 32'(fwd1), 0);
        next();
        rs1 = '0;
        rs2 = '0;

        // Asynchronous reset drops a pending write.
        req_a = '{valid: 1'b1, ws: 4'd11, wd: 32'hCAFE0011};
        next();
        req_a.valid = 1'b0;
        #2;
        check("t5_we_before", 32'(we), 1);
        rst_n = 1'b0;
        #1;
        check("t5_we_async", 32'(we), 0);
        check("t5_ws_async", 32'(ws), 0);
        check("t5_wd_async", wd, 0);
        next();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("t5_no_write", 32'(we), 0);
            next();
        end

        // Same target register on both requesters.
        req_a = '{valid: 1'b1, ws: 4'd4, wd: 32'h1};
        req_b = '{valid: 1'b1, ws: 4'd4, wd: 32'h2};
        at_neg();
        check("t6_a_first", 32'(a_ready), 1);
        next();
        req_a.valid = 1'b0;
        at_neg();
        check("t6_ws", 32'(ws), 4);
        check("t6_wd_a", wd, 32'h1);
        check("t6_b_ready", 32'(b_ready), 1);
        check("t6_no_force", 32'(starved), 0);
        next();
        req_b.valid = 1'b0;
        at_neg();
        check("t6_we_b", 32'(we), 1);
        check("t6_wd_b", wd, 32'h2);
        next();

        // Randomized traffic honouring the hold-until-accepted rule.
        for (int n = 0; n < 600; n++) begin
            at_neg();
            ar = a_ready;
            br = b_ready;
            next();
            if (!(req_a.valid && !ar)) begin
                req_a.valid = ($urandom_range(0, 9) < 6);
                req_a.ws    = RF_SEL_W'($urandom_range(0, 15));
                req_a.wd    = $urandom;
            end
            if (!(req_b.valid && !br)) begin
                req_b.valid = ($urandom_range(0, 9) < 7);
                req_b.ws    = RF_SEL_W'($urandom_range(0, 15));
                req_b.wd    = $urandom;
            end
            rs1 = RF_SEL_W'($urandom_range(0, 15));
            rs2 = ($urandom_range(0, 1) == 1) ? req_a.ws : RF_SEL_W'($urandom_range(0, 15));
        end
        at_neg();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: A (ALU result) and B (load unit).
- Fixed priority to A, with a starvation guard for B.
- Accepted writes are registered: one write strobe per cycle to the register file's write port (we/ws/wd).
- Provides a bypass path for read selectors while a registered write is still pending.

Parameters:
P_MAX_WAIT, 4, cycles B may be refused while valid before B is forced to win (legal range 1..15)
P_DATA_W, 32, write data width
P_SEL_W, 4, register selector width (16 registers)

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_a_valid  in  1  requester A has a write
o_a_ready  out  1  A accepted this cycle
i_a_ws  in  P_SEL_W  A target register
i_a_wd  in  P_DATA_W  A write data
i_b_valid  in  1  requester B has a write
o_b_ready  out  1  B accepted this cycle
i_b_ws  in  P_SEL_W  B target register
i_b_wd  in  P_DATA_W  B write data
o_we  out  1  register-file write enable (registered)
o_ws  out  P_SEL_W  register-file write selector (registered)
o_wd  out  P_DATA_W  register-file write data (registered)
i_rs1  in  P_SEL_W  read selector 1 (same value driven to the register file)
i_rs2  in  P_SEL_W  read selector 2
o_fwd1  out  1  bypass hit for rs1
o_fwd2  out  1  bypass hit for rs2
o_fwd_data  out  P_DATA_W  bypass data (equals o_wd)
o_b_starved  out  1  force-B condition active (debug/perf)

Behaviour:
- Reset: asynchronous, active-low.
  - Clears o_we, o_ws, o_wd, the wait counter and o_b_starved to 0.
  - A write registered but not yet committed is dropped; it never reaches the register file.
  - With no valid requests, o_a_ready and o_b_ready are 0.
- Grant (combinational, one winner per cycle; readys may depend on valids):
  - force_b = (wait_cnt == P_MAX_WAIT).
  - If force_b and B valid: B wins.
  - Else if A valid: A wins.
  - Else if B valid: B wins.
  - The winner's ready = 1; the loser's ready = 0. A ready is never asserted without its valid.
- Handshake: transfer on valid && ready at a rising edge.
  - A refused requester holds valid, ws and wd stable until accepted.
  - Deasserting valid before acceptance is illegal; the assertion checks for it.
- Latency: transfer at edge N; o_we/o_ws/o_wd reflect it for cycle N..N+1; the register file commits at edge N+1.
  - o_we = 1 for exactly one cycle per transfer.
  - o_we = 0 in cycles with no transfer; o_ws/o_wd hold their last values.
- Throughput: one write per cycle sustained; no bubble between back-to-back grants.
- Wait counter (0..P_MAX_WAIT):
  - B valid and not granted: increment, saturating at P_MAX_WAIT.
  - B granted: clear to 0.
  - B not valid: clear to 0.
  - o_b_starved = force_b.
- Bypass: o_fwd1 = o_we && (i_rs1 == o_ws); o_fwd2 likewise for i_rs2; o_fwd_data = o_wd.
  - The consumer muxes o_fwd_data over the register-file read data when fwd is set.
- Same target register on A and B in one cycle: only the winner is written. B's write lands in a later cycle, so program order is the requesters' responsibility.
- Register 0 is an ordinary register: no special case.

Decomposition:
- Shared package: P_SEL_W, P_DATA_W, number of registers (16), and a writeback request struct {valid, ws, wd}.
- One natural sub-module, regfile_wb_grant: combinational priority/force logic plus the wait counter.
- The output register and bypass compare stay in the top level.

Test Plan:
- Reset → all outputs 0. Then A valid only, ws=3, wd=0xDEADBEEF → o_a_ready=1 that cycle; next cycle o_we=1, o_ws=3, o_wd=0xDEADBEEF; following cycle o_we=0.
- A and B valid continuously (A ws=1, B ws=2), P_MAX_WAIT=4 → A granted 4 cycles, o_b_starved=1 in the 5th, B granted, counter 0. Pattern repeats: exactly 1 B write per 5 writes.
- B only, 3 back-to-back transfers (ws=5,6,7) → o_we high 3 consecutive cycles; o_ws=5,6,7; wait counter stays 0.
- Bypass: A writes ws=9, wd=0x12345678; while o_we=1, i_rs1=9, i_rs2=8 → o_fwd1=1, o_fwd2=0, o_fwd_data=0x12345678. Next idle cycle → o_fwd1=0.
- Reset mid-operation: assert i_reset_n=0 asynchronously while o_we=1 → o_we drops immediately without a clock edge; no write is issued after reset release until a new handshake.
- Same target: A ws=4, wd=0x1 and B ws=4, wd=0x2 together, both held → o_ws=4, o_wd=0x1 first, then o_wd=0x2 next cycle (B now sole requester, no starvation needed).
